// File: rtl/lfsr_rng.sv
// XNOR Fibonacci LFSR with seed load, lock-up guard and period-wrap flag, plus a
// valid/ready draw port that returns a value below a requested bound by rejection sampling.
module lfsr_rng #(
  parameter int unsigned     WIDTH     = 10,
  parameter logic [WIDTH-1:0] TAPS     = 10'h240,
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter int unsigned     OUT_W     = 4,
  parameter int unsigned     MAX_TRIES = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed_in,
  input  logic             i_req_valid,
  input  logic [OUT_W-1:0] i_req_bound,
  output logic             o_req_ready,
  output logic             o_rnd_valid,
  input  logic             i_rnd_ready,
  output logic [OUT_W-1:0] o_rnd_data,
  output logic             o_rnd_err,
  output logic [WIDTH-1:0] o_state,
  output logic             o_lockup,
  output logic             o_wrap
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} st_e;

  st_e              r_st, w_st_d;
  logic [WIDTH-1:0] r_state, w_state_d;
  logic [WIDTH-1:0] r_start, w_start_d;
  logic [WIDTH-1:0] r_cnt, w_cnt_d;
  logic [OUT_W-1:0] r_bound, w_bound_d;
  logic [TW-1:0]    r_tries, w_tries_d;
  logic [OUT_W-1:0] r_data, w_data_d;
  logic             r_err, w_err_d;
  logic             r_lockup, w_lockup_d;
  logic             r_wrap, w_wrap_d;

  logic [WIDTH-1:0] w_step;
  logic [OUT_W-1:0] w_cand;
  logic [WIDTH-1:0] w_seed;
  logic             w_seed_ones;

  assign w_step      = {r_state[WIDTH-2:0], ~^(r_state & TAPS)};
  assign w_cand      = w_step[OUT_W-1:0];
  assign w_seed_ones = &i_seed_in;
  // All-ones is the XNOR fixed point, so it is never allowed into the register.
  assign w_seed      = w_seed_ones ? '0 : i_seed_in;

  always_comb begin
    w_st_d     = r_st;
    w_state_d  = r_state;
    w_start_d  = r_start;
    w_cnt_d    = r_cnt;
    w_bound_d  = r_bound;
    w_tries_d  = r_tries;
    w_data_d   = r_data;
    w_err_d    = r_err;
    w_lockup_d = 1'b0;
    w_wrap_d   = 1'b0;

    if (i_load) begin
      w_state_d  = w_seed;
      w_start_d  = w_seed;
      w_cnt_d    = '0;
      w_lockup_d = w_seed_ones;
    end else if ((r_st == StSearch) || i_en) begin
      w_state_d = w_step;
      if (w_step == r_start) begin
        w_wrap_d = 1'b1;
        w_cnt_d  = '0;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end

    unique case (r_st)
      StIdle: begin
        if (i_req_valid) begin
          w_bound_d = i_req_bound;
          w_tries_d = '0;
          if (i_req_bound == '0) begin
            w_st_d   = StDone;
            w_data_d = '0;
            w_err_d  = 1'b1;
          end else begin
            w_st_d = StSearch;
          end
        end
      end
      StSearch: begin
        // A load replaces the step this cycle, so there is no candidate to judge.
        if (!i_load) begin
          if (w_cand < r_bound) begin
            w_st_d   = StDone;
            w_data_d = w_cand;
            w_err_d  = 1'b0;
          end else if (r_tries == TW'(MAX_TRIES - 1)) begin
            w_st_d   = StDone;
            w_data_d = '0;
            w_err_d  = 1'b1;
          end else begin
            w_tries_d = r_tries + 1'b1;
          end
        end
      end
      StDone: begin
        if (i_rnd_ready) begin
          w_st_d = StIdle;
        end
      end
      default: w_st_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_st     <= StIdle;
      r_state  <= SEED;
      r_start  <= SEED;
      r_cnt    <= '0;
      r_bound  <= '0;
      r_tries  <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_lockup <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_st     <= w_st_d;
      r_state  <= w_state_d;
      r_start  <= w_start_d;
      r_cnt    <= w_cnt_d;
      r_bound  <= w_bound_d;
      r_tries  <= w_tries_d;
      r_data   <= w_data_d;
      r_err    <= w_err_d;
      r_lockup <= w_lockup_d;
      r_wrap   <= w_wrap_d;
    end
  end

  assign o_req_ready = (r_st == StIdle);
  assign o_rnd_valid = (r_st == StDone);
  assign o_rnd_data  = r_data;
  assign o_rnd_err   = r_err;
  assign o_state     = r_state;
  assign o_lockup    = r_lockup;
  assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: LFSR sequence, wrap, lock-up and scoreboarded draws.
module tb_lfsr_rng;

  localparam int unsigned W  = 10;
  localparam int unsigned OW = 4;

  typedef struct {
    logic [OW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, en, load, req_valid, rnd_ready;
  logic [W-1:0]  seed_in;
  logic [OW-1:0] req_bound;
  logic          req_ready, rnd_valid, rnd_err, lockup, wrap;
  logic [OW-1:0] rnd_data;
  logic [W-1:0]  state;
  logic          d1_req_ready, d1_rnd_valid, d1_rnd_err, d1_lockup, d1_wrap;
  logic [OW-1:0] d1_rnd_data;
  logic [W-1:0]  d1_state;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  lfsr_rng u_dut (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_load(load), .i_seed_in(seed_in),
    .i_req_valid(req_valid), .i_req_bound(req_bound), .o_req_ready(req_ready),
    .o_rnd_valid(rnd_valid), .i_rnd_ready(rnd_ready), .o_rnd_data(rnd_data),
    .o_rnd_err(rnd_err), .o_state(state), .o_lockup(lockup), .o_wrap(wrap)
  );

  lfsr_rng #(.MAX_TRIES(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_load(load), .i_seed_in(seed_in),
    .i_req_valid(req_valid), .i_req_bound(req_bound), .o_req_ready(d1_req_ready),
    .o_rnd_valid(d1_rnd_valid), .i_rnd_ready(rnd_ready), .o_rnd_data(d1_rnd_data),
    .o_rnd_err(d1_rnd_err), .o_state(d1_state), .o_lockup(d1_lockup), .o_wrap(d1_wrap)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] m_step(input logic [W-1:0] s);
    logic [W-1:0] taps;
    taps = 10'h240;
    return {s[W-2:0], ~^(s & taps)};
  endfunction

  // Reference draw: rejection sampling on the low OW bits of each new state.
  task automatic m_draw(input logic [W-1:0] s0, input logic [OW-1:0] bnd, input int maxt,
                        output exp_t e, output logic [W-1:0] s_end);
    logic [W-1:0] s;
    bit           done;
    s      = s0;
    e.data = '0;
    e.err  = 1'b1;
    e.lat  = 0;
    done   = 1'b0;
    if (bnd != '0) begin
      for (int i = 0; i < maxt; i++) begin
        if (!done) begin
          s = m_step(s);
          e.lat++;
          if (s[OW-1:0] < bnd) begin
            e.data = s[OW-1:0];
            e.err  = 1'b0;
            done   = 1'b1;
          end
        end
      end
    end
    s_end = s;
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    while (!rnd_valid && lat < budget) begin
      tick();
      lat++;
    end
    if (!rnd_valid) check_eq("rnd_valid_timeout", 32'(rnd_valid), 32'd1);
  endtask

  task automatic pop_compare(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_data"}, 32'(rnd_data), 32'(e.data));
      check_eq({tag, "_err"}, 32'(rnd_err), 32'(e.err));
      check_eq({tag, "_lat"}, 32'(lat), 32'(e.lat));
    end
  endtask

  task automatic do_draw(input string tag, input logic [W-1:0] s0, input logic [OW-1:0] bnd,
                         input int stall, output logic [W-1:0] s_end);
    exp_t e;
    int   lat;
    m_draw(s0, bnd, 16, e, s_end);
    sb.push_back(e);
    req_valid = 1'b1;
    req_bound = bnd;
    tick();
    req_valid = 1'b0;
    wait_valid(40, lat);
    pop_compare(tag, lat);
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq({tag, "_hold_valid"}, 32'(rnd_valid), 32'd1);
      check_eq({tag, "_hold_data"}, 32'(rnd_data), 32'(e.data));
      check_eq({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    check_eq({tag, "_released"}, 32'(rnd_valid), 32'd0);
    check_eq({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] seq1 [8];
    logic [W-1:0] s_end;
    bit           seen [1024];
    int           wraps, wrap_at, repeats, lat;
    exp_t         e;

    seq1 = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    reset = 1'b0; en = 1'b0; load = 1'b0; seed_in = '0;
    req_valid = 1'b0; req_bound = '0; rnd_ready = 1'b0;

    // Reset state and first eight steps.
    do_reset();
    check_eq("rst_state", 32'(state), 32'h0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rnd_valid", 32'(rnd_valid), 32'd0);
    check_eq("rst_rnd_data", 32'(rnd_data), 32'd0);
    check_eq("rst_flags", 32'({lockup, wrap, rnd_err}), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("seq_%0d", i), 32'(state), 32'(seq1[i]));
    end
    en = 1'b0;

    // Full period: exactly one wrap, at step 1023, and no repeats before it.
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    seen[0] = 1'b1;
    wraps = 0; wrap_at = 0; repeats = 0;
    en = 1'b1;
    for (int step = 1; step <= 1023; step++) begin
      tick();
      if (wrap) begin
        wraps++;
        wrap_at = step;
      end
      if (step < 1023 && seen[state]) repeats++;
      seen[state] = 1'b1;
    end
    en = 1'b0;
    check_eq("wrap_count", 32'(wraps), 32'd1);
    check_eq("wrap_step", 32'(wrap_at), 32'd1023);
    check_eq("wrap_state", 32'(state), 32'h0);
    check_eq("period_repeats", 32'(repeats), 32'd0);
    tick();
    check_eq("wrap_pulse_len", 32'(wrap), 32'd0);

    // Lock-up protection on an all-ones seed.
    load = 1'b1; seed_in = 10'h3FF;
    tick();
    load = 1'b0;
    check_eq("lockup_state", 32'(state), 32'h0);
    check_eq("lockup_pulse", 32'(lockup), 32'd1);
    tick();
    check_eq("lockup_clear", 32'(lockup), 32'd0);
    load = 1'b1; seed_in = 10'h155;
    tick();
    load = 1'b0;
    check_eq("load_state", 32'(state), 32'h155);
    check_eq("load_no_lockup", 32'(lockup), 32'd0);

    // Draws from reset: bound 5 with stall, bound 0, then a chain tracked by the model.
    do_reset();
    do_draw("draw_b5", 10'h000, 4'd5, 3, s_end);
    check_eq("draw_b5_state", 32'(state), 32'(s_end));
    do_draw("draw_b0", s_end, 4'd0, 0, s_end);
    do_draw("draw_b3", s_end, 4'd3, 1, s_end);
    do_draw("draw_b12", s_end, 4'd12, 0, s_end);
    do_draw("draw_b1", s_end, 4'd1, 0, s_end);
    check_eq("draw_chain_state", 32'(state), 32'(s_end));

    // Retry cap of one: seed 0 steps to 0x001, nibble 1 is not below bound 1.
    do_reset();
    req_valid = 1'b1; req_bound = 4'd1;
    tick();
    req_valid = 1'b0;
    tick();
    check_eq("cap1_valid", 32'(d1_rnd_valid), 32'd1);
    check_eq("cap1_err", 32'(d1_rnd_err), 32'd1);
    check_eq("cap1_data", 32'(d1_rnd_data), 32'd0);
    check_eq("cap1_state", 32'(d1_state), 32'h001);

    // Reset mid-search aborts the draw.
    check_eq("abort_searching", 32'(rnd_valid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_state", 32'(state), 32'h0);
    check_eq("abort_idle", 32'(req_ready), 32'd1);
    check_eq("abort_no_valid", 32'(rnd_valid), 32'd0);
    tick();
    check_eq("abort_still_idle", 32'(rnd_valid), 32'd0);

    // Load during search: seed wins, search restarts from it with tries intact.
    req_valid = 1'b1; req_bound = 4'd1;
    tick();
    req_valid = 1'b0;
    load = 1'b1; seed_in = 10'h155;
    tick();
    load = 1'b0;
    check_eq("sload_state", 32'(state), 32'h155);
    m_draw(10'h155, 4'd1, 16, e, s_end);
    sb.push_back(e);
    wait_valid(40, lat);
    pop_compare("sload", lat);
    check_eq("sload_end_state", 32'(state), 32'(s_end));
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    check_eq("sload_released", 32'(rnd_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
